// File: rtl/bus_demux_pkg.sv
// bus_demux_pkg
//   Shared types and helpers for the 1-to-2 bus demultiplexer.
//   - chan_e   : destination channel encoding carried by in_sel
//   - calc_lw  : width needed to hold an occupancy count of 0..depth
package bus_demux_pkg;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

    // Number of bits needed to represent the value 'depth', which is
    // the same as $clog2(depth+1) for any depth >= 1.
    function automatic int calc_lw(input int depth);
        int w;
        int v;
        w = 32'sd0;
        v = depth;
        while (v > 32'sd0) begin
            w = w + 32'sd1;
            v = v >> 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_demux_fifo.sv
// bus_demux_fifo
//   Single-clock FIFO used once per demux output channel. Occupancy is
//   tracked in a separate level counter so that full and empty never alias
//   when the pointers are equal. The head word comes straight from storage.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears storage too)
//   push        : write push_data this cycle (ignored when full)
//   push_data   : word to store
//   full        : level == DEPTH
//   pop         : consumer takes the head word (ignored when empty)
//   head_data   : word at the read pointer
//   empty       : level == 0
//   level       : occupancy 0..DEPTH
module bus_demux_fifo
    import bus_demux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int LW    = calc_lw(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard against pushing into a full or popping from an empty FIFO even if
    // the caller does not, so the level can never leave 0..DEPTH.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == LW'(0));
    assign level     = r_level;
    assign head_data = r_mem[r_rd_ptr];

    // Storage write; reset clears every entry so head_data reads 0 afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH through natural overflow (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Level counter: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= LW'(0);
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/bus_demux.sv
// bus_demux
//   Routes each word accepted on the input valid/ready channel into one of two
//   per-channel FIFOs according to in_sel; each FIFO drains through its own
//   valid/ready output channel. in_ready depends only on in_sel and the
//   registered FIFO level, so there is no path from outN_ready to in_ready.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_data/in_sel/in_valid    : input word, destination, valid
//   in_ready                   : selected channel is not full
//   outN_data/outN_valid       : channel N head word, channel N non-empty
//   outN_ready                 : channel N consumer takes the head word
//   outN_level                 : channel N occupancy 0..DEPTH
module bus_demux
    import bus_demux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int LW    = calc_lw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [LW-1:0]    out0_level,
    output logic [LW-1:0]    out1_level
);

    chan_e w_sel;
    logic  w_full0;
    logic  w_full1;
    logic  w_empty0;
    logic  w_empty1;
    logic  w_push0;
    logic  w_push1;

    assign w_sel = chan_e'(in_sel);

    // in_ready mux: ready reflects only the fullness of the addressed channel.
    always_comb begin
        in_ready = 1'b0;
        case (w_sel)
            CH0:     in_ready = ~w_full0;
            CH1:     in_ready = ~w_full1;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_push0 = in_valid & in_ready & (w_sel == CH0);
    assign w_push1 = in_valid & in_ready & (w_sel == CH1);

    assign out0_valid = ~w_empty0;
    assign out1_valid = ~w_empty1;

    bus_demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push0),
        .push_data (in_data),
        .full      (w_full0),
        .pop       (out0_ready),
        .head_data (out0_data),
        .empty     (w_empty0),
        .level     (out0_level)
    );

    bus_demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push1),
        .push_data (in_data),
        .full      (w_full1),
        .pop       (out1_ready),
        .head_data (out1_data),
        .empty     (w_empty1),
        .level     (out1_level)
    );

endmodule

// File: tb/tb_bus_demux.sv
// tb_bus_demux
//   Directed-vector bench for bus_demux (WIDTH=4, DEPTH=4). Inputs change
//   1 time unit after each rising edge; outputs are checked at that point,
//   so they reflect the state left by the preceding edge.
module tb_bus_demux;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [LW-1:0]    out0_level;
    logic [LW-1:0]    out1_level;

    int n_checks;
    int n_pass;

    bus_demux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out0_level (out0_level),
        .out1_level (out1_level)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        in_data    = 4'h0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // ---------------- reset ----------------
        repeat (3) step();
        check_eq("rst_v0",  out0_valid, 0);
        check_eq("rst_v1",  out1_valid, 0);
        check_eq("rst_l0",  out0_level, 0);
        check_eq("rst_l1",  out1_level, 0);
        check_eq("rst_d0",  out0_data,  0);
        in_sel = 1'b0; #1;
        check_eq("rst_rdy_s0", in_ready, 1);
        in_sel = 1'b1; #1;
        check_eq("rst_rdy_s1", in_ready, 1);
        rst_n = 1'b1;
        step();

        // ---------------- routing ----------------
        push(1'b0, 4'h3);
        push(1'b1, 4'hA);
        push(1'b0, 4'h5);
        check_eq("route_l0", out0_level, 2);
        check_eq("route_l1", out1_level, 1);
        check_eq("route_d0", out0_data,  4'h3);
        check_eq("route_d1", out1_data,  4'hA);
        check_eq("route_v1", out1_valid, 1);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        check_eq("route_d0b", out0_data,  4'h5);
        check_eq("route_l1b", out1_level, 0);
        check_eq("route_v1b", out1_valid, 0);
        step();
        check_eq("route_l0c", out0_level, 0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // ---------------- full and wrap ----------------
        for (int i = 1; i <= 4; i++) push(1'b0, 4'(i));
        check_eq("full_l0", out0_level, 4);
        in_sel = 1'b0; #1;
        check_eq("full_rdy_s0", in_ready, 0);
        in_sel = 1'b1; #1;
        check_eq("full_rdy_s1", in_ready, 1);
        out0_ready = 1'b1;
        check_eq("drain_1", out0_data, 4'h1);
        step();
        check_eq("drain_2", out0_data, 4'h2);
        step();
        out0_ready = 1'b0;
        check_eq("pop2_l0", out0_level, 2);
        push(1'b0, 4'h5);
        push(1'b0, 4'h6);
        check_eq("wrap_l0", out0_level, 4);

        // ---------------- full with simultaneous pop ----------------
        out0_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 4'h7;
        #1;
        check_eq("fpop_rdy", in_ready, 0);
        check_eq("drain_3", out0_data, 4'h3);
        step();
        check_eq("fpop_l0", out0_level, 3);
        check_eq("fpop_rdy2", in_ready, 1);
        out0_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("fpop_l0b", out0_level, 4);
        out0_ready = 1'b1;
        for (int i = 4; i <= 7; i++) begin
            check_eq("drain_n", out0_data, i);
            step();
        end
        out0_ready = 1'b0;
        check_eq("drain_empty", out0_valid, 0);

        // ---------------- streaming ----------------
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 4'(i);
            step();
            check_eq("stream_lvl", int'(out1_level <= 3'd1), 1);
            check_eq("stream_v1",  out1_valid, 1);
            check_eq("stream_d1",  out1_data,  i);
        end
        in_valid = 1'b0;
        step();
        check_eq("stream_end_l1", out1_level, 0);
        out1_ready = 1'b0;

        // ---------------- async reset mid-stream ----------------
        push(1'b0, 4'h8);
        push(1'b1, 4'hB);
        push(1'b0, 4'h9);
        push(1'b1, 4'hC);
        push(1'b0, 4'hA);
        push(1'b1, 4'hD);
        check_eq("pre_rst_l0", out0_level, 3);
        check_eq("pre_rst_l1", out1_level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_v0", out0_valid, 0);
        check_eq("arst_v1", out1_valid, 0);
        check_eq("arst_l0", out0_level, 0);
        check_eq("arst_l1", out1_level, 0);
        check_eq("arst_d1", out1_data,  0);
        #1;
        rst_n = 1'b1;
        step();
        step();
        check_eq("post_rst_v0", out0_valid, 0);
        check_eq("post_rst_l1", out1_level, 0);
        push(1'b0, 4'hE);
        check_eq("post_rst_d0", out0_data,  4'hE);
        check_eq("post_rst_l0", out0_level, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_demux.md
# bus_demux

Sequential 1-to-2 bus demultiplexer, the receive-side counterpart of the 2:1 bus select. It accepts a WIDTH-bit word plus a select bit on a valid/ready input channel. Each accepted word goes into a per-channel FIFO of depth DEPTH. Two independent valid/ready output channels drain the FIFOs. It sits between a single shared bus producer and two downstream consumers that run at different rates.

## Interface
- WIDTH, 4, data word width in bits
- DEPTH, 4, entries per channel FIFO; power of two, >= 2
- LW, $clog2(DEPTH+1), width of the level outputs (localparam)

- clk  input  1  single clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  selected channel can accept this cycle
- out0_data  output  WIDTH  channel 0 head word
- out0_valid  output  1  channel 0 FIFO non-empty
- out0_ready  input  1  channel 0 consumer accepts head
- out1_data  output  WIDTH  channel 1 head word
- out1_valid  output  1  channel 1 FIFO non-empty
- out1_ready  input  1  channel 1 consumer accepts head
- out0_level  output  LW  channel 0 occupancy, 0..DEPTH
- out1_level  output  LW  channel 1 occupancy, 0..DEPTH

## Operation
- Reset (rst_n low, async): all pointers and levels are 0. outN_valid = 0. outN_level = 0. outN_data = 0, because storage is cleared. in_ready follows the combinational rule below and reads 1 during reset.
- in_ready = ~full[in_sel]. It is combinational from in_sel and the registered level only. It has no dependence on in_valid or outN_ready.
- Input transfer: in_valid & in_ready at a posedge. The word is written at the selected FIFO's wr_ptr, wr_ptr increments, and the level increments.
- Output transfer on channel N: outN_valid & outN_ready at a posedge. rd_ptr increments and the level decrements.
- outN_valid = (level_N != 0). outN_data = mem_N[rd_ptr_N], driven directly from storage with no output register.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. Level is tracked separately so that full and empty are unambiguous.
- Simultaneous push and pop on the same channel: both occur and the level is unchanged. This is legal whenever level is in 1..DEPTH-1.
- Full channel: in_ready = 0 for that in_sel, even when outN_ready is high in the same cycle. The block never accepts a push into a full FIFO.
- Empty channel: outN_valid = 0 and outN_ready is ignored.
- A push into channel A and a pop from channel B in the same cycle are fully independent.
- Word order is preserved per channel. There is no ordering guarantee across channels.
- Async reset mid-operation discards all stored words immediately. Outputs return to reset values without waiting for a clock edge.

## Timing
- Input-to-output latency: a word accepted at edge k is visible with outN_valid = 1 after edge k, i.e. in cycle k+1. It can be popped at edge k+1 at the earliest.
- Throughput: 1 word/cycle input. Each channel sustains 1 word/cycle output.
- Backpressure: in_ready recovers in the cycle after the pop edge that frees a slot.
- There are no combinational paths from outN_ready to in_ready or to any output.

## Structure
- Package bus_demux_pkg contains:
  - chan_e enum: CH0 = 1'b0, CH1 = 1'b1.
  - A function computing LW from DEPTH.
- Sub-module bus_demux_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, push_data, full, pop, head_data, empty, level.
  - Instantiated twice.
- The top level holds only the in_sel decode, the push gating, and the in_ready mux.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles. Expect both outN_valid = 0, both levels = 0, and in_ready = 1 for both in_sel values.
- Routing: send 0x3 (sel=0), 0xA (sel=1), 0x5 (sel=0) back-to-back with both readies low. Expect out0_level = 2 and out1_level = 1. Expect out0_data = 0x3 and out1_data = 0xA.
- Full and wrap: with out0_ready = 0, push 0x1..0x4 to channel 0. Expect in_ready = 0 for sel=0 and in_ready = 1 for sel=1. Pop 2 words, then push 0x5 and 0x6. Expect the drain order 0x1..0x6.
- Full with simultaneous pop: with channel 0 full, assert out0_ready = 1 and in_valid with sel=0 for 1 cycle. Expect only the pop to occur, level 4 -> 3. The push is accepted on the next cycle.
- Streaming: keep out1_ready high and push 16 words 0x0..0xF with sel=1 on consecutive cycles. Expect out1_level to stay ≤ 1 and all 16 words out in order, each 1 cycle after it is accepted.
- Async reset mid-stream: with 3 words queued on each channel, pulse rst_n low between clock edges. Expect valids and levels to be 0 immediately, with no stale words after rst_n rises.
